// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32IM core.
// Base ALU, address, link and branch logic are combinational into the
// EX/MEM register owned here. RV32M ops use an iterative 32-step unit
// that stalls the front end while it works.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rd_i,
  input  logic [31:0] imm_ext_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] PC_i,
  output logic        stall_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o,
  output logic [4:0]  rd_o,
  output logic [31:0] result_o,
  output logic [31:0] store_data_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // The bubble is encoded as ADDI x0, x0, 0.
  localparam logic [6:0] OPCODE_NOP = OPC_OPIMM;
  localparam logic [2:0] FUNCT3_NOP = 3'b000;

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mState_t;

  mState_t     r_state;
  mState_t     w_nextState;
  logic [4:0]  r_count;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_negA;
  logic        r_negB;
  logic        r_divZero;

  logic        w_stall;
  logic        w_isMop;
  logic        w_isDiv;
  logic        w_signA;
  logic        w_signB;
  logic [31:0] w_magA;
  logic [31:0] w_magB;
  logic [32:0] w_mulSum;
  logic [32:0] w_divRem;
  logic        w_divGe;
  logic [31:0] w_divSub;
  logic [63:0] w_stepAcc;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_mResult;

  logic [31:0] w_opB;
  logic [4:0]  w_shamt;
  logic [31:0] w_sra;
  logic [31:0] w_aluResult;
  logic        w_brCond;
  logic [31:0] w_pcImm;
  logic [31:0] w_rs1Imm;
  logic [31:0] w_pcPlus4;
  logic        w_known;
  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_baseResult;

  // Operand conditioning for the M unit: signed variants work on magnitudes.
  assign w_isMop = (opcode_i == OPC_OP) && (funct7_i == 7'b0000001);
  assign w_isDiv = funct3_i[2];
  assign w_signA = (funct3_i != 3'b011) && (funct3_i != 3'b101) && (funct3_i != 3'b111);
  assign w_signB = w_signA && (funct3_i != 3'b010);
  assign w_magA  = (w_signA && rs1_data_i[31]) ? (32'd0 - rs1_data_i) : rs1_data_i;
  assign w_magB  = (w_signB && rs2_data_i[31]) ? (32'd0 - rs2_data_i) : rs2_data_i;

  // M unit state register; reset abandons any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= M_IDLE;
    else        r_state <= w_nextState;
  end

  // M unit sequencing and the front-end stall.
  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    case (r_state)
      M_IDLE: begin
        if (w_isMop) begin
          w_stall     = 1'b1;
          w_nextState = M_BUSY;
        end
      end
      M_BUSY: begin
        w_stall = 1'b1;
        if (r_count == 5'd31) w_nextState = M_DONE;
      end
      M_DONE:  w_nextState = M_IDLE;
      default: w_nextState = M_IDLE;
    endcase
  end

  assign stall_o = w_stall;

  // One iteration: multiply adds the multiplicand into the upper half and
  // shifts right; divide shifts left and subtracts the divisor if it fits.
  assign w_mulSum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_divRem = r_acc[63:31];
  assign w_divGe  = (w_divRem >= {1'b0, r_opnd});
  assign w_divSub = w_divRem[31:0] - r_opnd;

  // Pick the step result for the op in flight.
  always_comb begin
    w_stepAcc = {w_mulSum, r_acc[31:1]};
    if (w_isDiv) begin
      if (w_divGe) w_stepAcc = {w_divSub, r_acc[30:0], 1'b1};
      else         w_stepAcc = {w_divRem[31:0], r_acc[30:0], 1'b0};
    end
  end

  // M unit datapath: latch magnitudes on entry, then iterate while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 5'd0;
      r_acc     <= 64'd0;
      r_opnd    <= 32'd0;
      r_negA    <= 1'b0;
      r_negB    <= 1'b0;
      r_divZero <= 1'b0;
    end else if (r_state == M_IDLE && w_isMop) begin
      r_count   <= 5'd0;
      r_acc     <= {32'd0, (w_isDiv ? w_magA : w_magB)};
      r_opnd    <= w_isDiv ? w_magB : w_magA;
      r_negA    <= w_signA && rs1_data_i[31];
      r_negB    <= w_signB && rs2_data_i[31];
      r_divZero <= (rs2_data_i == 32'd0);
    end else if (r_state == M_BUSY) begin
      r_count <= r_count + 5'd1;
      r_acc   <= w_stepAcc;
    end
  end

  // Sign fix-up and divide-by-zero results; the ID/EX inputs are still
  // held during DONE, so funct3 and the dividend come straight from them.
  always_comb begin
    w_prod = (r_negA ^ r_negB) ? (64'd0 - r_acc) : r_acc;
    w_quot = (r_negA ^ r_negB) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    w_rem  = r_negA ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    if (r_divZero) begin
      w_quot = 32'hFFFF_FFFF;
      w_rem  = rs1_data_i;
    end
    case (funct3_i)
      3'b000:          w_mResult = w_prod[31:0];
      3'b001, 3'b010,
      3'b011:          w_mResult = w_prod[63:32];
      3'b100, 3'b101:  w_mResult = w_quot;
      default:         w_mResult = w_rem;
    endcase
  end

  assign w_opB     = (opcode_i == OPC_OP) ? rs2_data_i : imm_ext_i;
  assign w_shamt   = w_opB[4:0];
  assign w_sra     = $signed(rs1_data_i) >>> w_shamt;
  assign w_pcImm   = PC_i + imm_ext_i;
  assign w_rs1Imm  = rs1_data_i + imm_ext_i;
  assign w_pcPlus4 = PC_i + 32'd4;

  // Integer ALU shared by OP and OP-IMM; SUB only exists for register form.
  always_comb begin
    w_aluResult = 32'd0;
    case (funct3_i)
      3'b000: w_aluResult = (opcode_i == OPC_OP && funct7_i[5]) ? (rs1_data_i - w_opB)
                                                               : (rs1_data_i + w_opB);
      3'b001: w_aluResult = rs1_data_i << w_shamt;
      3'b010: w_aluResult = {31'd0, ($signed(rs1_data_i) < $signed(w_opB))};
      3'b011: w_aluResult = {31'd0, (rs1_data_i < w_opB)};
      3'b100: w_aluResult = rs1_data_i ^ w_opB;
      3'b101: w_aluResult = funct7_i[5] ? w_sra : (rs1_data_i >> w_shamt);
      3'b110: w_aluResult = rs1_data_i | w_opB;
      3'b111: w_aluResult = rs1_data_i & w_opB;
      default: w_aluResult = 32'd0;
    endcase
  end

  // Branch condition by funct3; reserved encodings never branch.
  always_comb begin
    w_brCond = 1'b0;
    case (funct3_i)
      3'b000:  w_brCond = (rs1_data_i == rs2_data_i);
      3'b001:  w_brCond = (rs1_data_i != rs2_data_i);
      3'b100:  w_brCond = ($signed(rs1_data_i) < $signed(rs2_data_i));
      3'b101:  w_brCond = ($signed(rs1_data_i) >= $signed(rs2_data_i));
      3'b110:  w_brCond = (rs1_data_i < rs2_data_i);
      3'b111:  w_brCond = (rs1_data_i >= rs2_data_i);
      default: w_brCond = 1'b0;
    endcase
  end

  // Opcode decode: base result, redirect and whether the op is known.
  always_comb begin
    w_known      = 1'b1;
    w_taken      = 1'b0;
    w_target     = w_pcImm;
    w_baseResult = 32'd0;
    case (opcode_i)
      OPC_OP, OPC_OPIMM: w_baseResult = w_aluResult;
      OPC_LUI:           w_baseResult = imm_ext_i;
      OPC_AUIPC:         w_baseResult = w_pcImm;
      OPC_JAL: begin
        w_baseResult = w_pcPlus4;
        w_taken      = 1'b1;
      end
      OPC_JALR: begin
        w_baseResult = w_pcPlus4;
        w_taken      = 1'b1;
        w_target     = {w_rs1Imm[31:1], 1'b0};
      end
      OPC_BRANCH:          w_taken      = w_brCond;
      OPC_LOAD, OPC_STORE: w_baseResult = w_rs1Imm;
      default:             w_known      = 1'b0;
    endcase
  end

  assign branch_taken_o  = w_taken;
  assign branch_target_o = w_target;

  // EX/MEM register: bubble while stalled or for unknown opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_o         <= 5'd0;
      result_o     <= 32'd0;
      store_data_o <= 32'd0;
      opcode_o     <= OPCODE_NOP;
      funct3_o     <= FUNCT3_NOP;
    end else if (w_stall || !w_known) begin
      rd_o         <= 5'd0;
      result_o     <= 32'd0;
      store_data_o <= 32'd0;
      opcode_o     <= OPCODE_NOP;
      funct3_o     <= FUNCT3_NOP;
    end else begin
      rd_o         <= rd_i;
      result_o     <= w_isMop ? w_mResult : w_baseResult;
      store_data_o <= rs2_data_i;
      opcode_o     <= opcode_i;
      funct3_o     <= funct3_i;
    end
  end

endmodule
